// File: rtl/dma_busmaster_if.sv
// ---------------------------------------------------------------------------
// dma_busmaster_if
// Groups the local request port and the 68030-side bus signals of
// dma_busmaster. Bus signals are active-low levels; the board provides the
// open-drain / tri-state buffers controlled by BUS_OE and DATA_OE.
//
//   Local request side : REQ, REQ_RnW, REQ_SIZ, REQ_ADDR, REQ_WDATA (to block)
//                        BUSY, DONE, ERR, RDATA, PORTSZ           (from block)
//   Arbitration        : nBR, nBGACK (out), nBG, nBGACK_IN, nAS_IN (in)
//   Bus cycle          : nAS, nDS, RnW, SIZ, ADDR, BUS_OE, DATA_OUT, DATA_OE (out)
//                        DATA_IN, nDSACK, nSTERM, nBERR (in)
//
// Modports: master = the bus initiator (dma_busmaster), slave = the agent /
// system environment facing it.
// ---------------------------------------------------------------------------
interface dma_busmaster_if;
    // Local request port
    logic        REQ;
    logic        REQ_RnW;
    logic [1:0]  REQ_SIZ;
    logic [31:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] RDATA;
    logic [1:0]  PORTSZ;
    // Arbitration
    logic        nBR;
    logic        nBG;
    logic        nBGACK_IN;
    logic        nBGACK;
    logic        nAS_IN;
    // Bus cycle
    logic        nAS;
    logic        nDS;
    logic        RnW;
    logic [1:0]  SIZ;
    logic [31:0] ADDR;
    logic        BUS_OE;
    logic [31:0] DATA_OUT;
    logic        DATA_OE;
    logic [31:0] DATA_IN;
    logic [1:0]  nDSACK;
    logic        nSTERM;
    logic        nBERR;

    modport master (
        input  REQ, REQ_RnW, REQ_SIZ, REQ_ADDR, REQ_WDATA,
        output BUSY, DONE, ERR, RDATA, PORTSZ,
        output nBR, nBGACK,
        input  nBG, nBGACK_IN, nAS_IN,
        output nAS, nDS, RnW, SIZ, ADDR, BUS_OE, DATA_OUT, DATA_OE,
        input  DATA_IN, nDSACK, nSTERM, nBERR
    );

    modport slave (
        output REQ, REQ_RnW, REQ_SIZ, REQ_ADDR, REQ_WDATA,
        input  BUSY, DONE, ERR, RDATA, PORTSZ,
        input  nBR, nBGACK,
        output nBG, nBGACK_IN, nAS_IN,
        input  nAS, nDS, RnW, SIZ, ADDR, BUS_OE, DATA_OUT, DATA_OE,
        output DATA_IN, nDSACK, nSTERM, nBERR
    );
endinterface

// File: rtl/dma_busmaster.sv
// ---------------------------------------------------------------------------
// dma_busmaster
// Single-transfer 68030 bus initiator. Accepts one request from the local
// port, arbitrates with BR/BG/BGACK, runs one asynchronous-style cycle and
// completes on BERR, STERM, DSACK or a local timeout, then pulses DONE with
// ERR/PORTSZ/RDATA.
//
// Ports:
//   CPU_CLK : bus clock, everything on its rising edge
//   RST     : synchronous, active-high reset
//   bus     : dma_busmaster_if.master (request port + bus signals)
//
// Every output is a register loaded from the next-state decode, so output
// levels always line up with the state the FSM is in.
// ---------------------------------------------------------------------------
module dma_busmaster #(
    parameter int unsigned TIMEOUT = 128
) (
    input  logic             CPU_CLK,
    input  logic             RST,
    dma_busmaster_if.master  bus
);

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_S0,
        ST_S1,
        ST_WAIT,
        ST_END,
        ST_REL
    } state_t;

    state_t        r_state;
    state_t        w_next;

    // Latched request
    logic          r_rnw;
    logic [1:0]    r_siz;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;

    logic [CW-1:0] r_cnt;

    // Termination decode (only meaningful in WAIT)
    logic          w_term;
    logic          w_term_err;
    logic [1:0]    w_term_psz;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CPU_CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and termination priority: BERR > STERM > DSACK > timeout
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_term     = 1'b0;
        w_term_err = 1'b0;
        w_term_psz = 2'b00;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.REQ) begin
                    w_next = ST_ARB;
                end
            end
            ST_ARB: begin
                // Grant is only taken once the previous master has left the bus
                if (!bus.nBG && bus.nAS_IN && bus.nBGACK_IN) begin
                    w_next = ST_S0;
                end
            end
            ST_S0: begin
                w_next = ST_S1;
            end
            ST_S1: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.nBERR) begin
                    w_term     = 1'b1;
                    w_term_err = 1'b1;
                    w_term_psz = 2'b00;
                end else if (!bus.nSTERM) begin
                    w_term     = 1'b1;
                    w_term_psz = 2'b11;
                end else if (bus.nDSACK != 2'b11) begin
                    w_term     = 1'b1;
                    w_term_psz = bus.nDSACK;
                end else if (r_cnt == CNT_LAST) begin
                    w_term     = 1'b1;
                    w_term_err = 1'b1;
                    w_term_psz = 2'b00;
                end
                if (w_term) begin
                    w_next = ST_END;
                end
            end
            ST_END: begin
                w_next = ST_REL;
            end
            ST_REL: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, timeout counter and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge CPU_CLK) begin
        if (RST) begin
            r_rnw      <= 1'b1;
            r_siz      <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            bus.ERR    <= 1'b0;
            bus.PORTSZ <= 2'b00;
            bus.RDATA  <= '0;
        end else begin
            if (r_state == ST_IDLE && bus.REQ) begin
                r_rnw   <= bus.REQ_RnW;
                r_siz   <= bus.REQ_SIZ;
                r_addr  <= bus.REQ_ADDR;
                r_wdata <= bus.REQ_WDATA;
            end

            // Counter saturates rather than wrapping
            if (w_next == ST_S1) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == ST_WAIT && w_term) begin
                bus.ERR    <= w_term_err;
                bus.PORTSZ <= w_term_psz;
                // Read data is kept untouched on an error completion
                if (r_rnw && !w_term_err) begin
                    bus.RDATA <= bus.DATA_IN;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered bus and handshake outputs, decoded from the next state
    // ------------------------------------------------------------------
    always_ff @(posedge CPU_CLK) begin
        if (RST) begin
            bus.nBR      <= 1'b1;
            bus.nBGACK   <= 1'b1;
            bus.nAS      <= 1'b1;
            bus.nDS      <= 1'b1;
            bus.RnW      <= 1'b1;
            bus.SIZ      <= 2'b00;
            bus.ADDR     <= '0;
            bus.BUS_OE   <= 1'b0;
            bus.DATA_OE  <= 1'b0;
            bus.DATA_OUT <= '0;
            bus.BUSY     <= 1'b0;
            bus.DONE     <= 1'b0;
        end else begin
            bus.nBR    <= (w_next != ST_ARB);
            bus.BUSY   <= (w_next == ST_ARB) || (w_next == ST_S0) || (w_next == ST_S1) ||
                          (w_next == ST_WAIT) || (w_next == ST_END);
            // Bus ownership spans S0..END; BG negation after this point is ignored
            bus.nBGACK <= !((w_next == ST_S0) || (w_next == ST_S1) ||
                            (w_next == ST_WAIT) || (w_next == ST_END));
            bus.BUS_OE <= (w_next == ST_S0) || (w_next == ST_S1) ||
                          (w_next == ST_WAIT) || (w_next == ST_END);
            bus.nAS    <= !((w_next == ST_S1) || (w_next == ST_WAIT));
            // Writes delay DS by one clock so data is stable before the strobe
            bus.nDS    <= !(((w_next == ST_S1) && r_rnw) || (w_next == ST_WAIT));
            bus.DATA_OE <= !r_rnw && ((w_next == ST_S1) || (w_next == ST_WAIT));
            bus.DONE   <= (w_next == ST_REL);

            if (w_next == ST_S0) begin
                bus.ADDR <= r_addr;
                bus.SIZ  <= r_siz;
                bus.RnW  <= r_rnw;
            end
            if (w_next == ST_S1 && !r_rnw) begin
                bus.DATA_OUT <= r_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dma_busmaster.sv
// ---------------------------------------------------------------------------
// tb_dma_busmaster
// Directed bench for dma_busmaster (TIMEOUT=8). Stimulus pushes the expected
// completion (cycle, ERR, RDATA, PORTSZ) into a scoreboard queue; a monitor
// pops and compares whenever DONE is seen. A responder process answers bus
// cycles with configurable termination after a chosen number of WAIT edges.
// ---------------------------------------------------------------------------
module tb_dma_busmaster;

    logic clk = 1'b0;
    logic rst;
    always #20 clk = ~clk;

    dma_busmaster_if bus();

    dma_busmaster #(.TIMEOUT(8)) dut (
        .CPU_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
        logic        chk_psz;
        logic [1:0]  psz;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   k_req  = 0;
    logic [31:0] m_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares each DONE pulse against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.DONE === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 want DONE=0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("done_cycle",     32'(cyc),        32'(e.due));
                chk("err",            32'(bus.ERR),    32'(e.err));
                chk("rdata",          bus.RDATA,       e.rdata);
                if (e.chk_psz) chk("portsz", 32'(bus.PORTSZ), 32'(e.psz));
                chk("busy_at_done",   32'(bus.BUSY),   32'd0);
                chk("bus_oe_at_done", 32'(bus.BUS_OE), 32'd0);
                chk("bgack_at_done",  32'(bus.nBGACK), 32'd1);
            end
        end
    end

    // Responder: asserts the configured termination so it is seen on the
    // rsp_wait-th WAIT edge (nAS falls entering S1, one clock before WAIT)
    int          rsp_wait  = 0;
    logic [1:0]  rsp_dsack = 2'b11;
    logic        rsp_sterm = 1'b0;
    logic        rsp_berr  = 1'b0;
    int          nlow      = 0;

    always @(negedge clk) begin
        if (bus.nAS === 1'b0) nlow = nlow + 1;
        else                  nlow = 0;
        if (rsp_wait != 0 && nlow == rsp_wait + 1) begin
            bus.nDSACK = rsp_dsack;
            bus.nSTERM = !rsp_sterm;
            bus.nBERR  = !rsp_berr;
        end else begin
            bus.nDSACK = 2'b11;
            bus.nSTERM = 1'b1;
            bus.nBERR  = 1'b1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_rsp(input int w, input logic [1:0] ds, input logic st,
                           input logic be, input logic [31:0] d);
        rsp_wait    = w;
        rsp_dsack   = ds;
        rsp_sterm   = st;
        rsp_berr    = be;
        bus.DATA_IN = d;
    endtask

    // Drives a one-clock REQ; returns at the negedge after it was sampled
    task automatic issue(input logic rnw, input logic [1:0] siz, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic push, input int lat,
                         input logic err, input logic [31:0] rdata,
                         input logic chk_psz, input logic [1:0] psz);
        exp_t e;
        bus.REQ_RnW   = rnw;
        bus.REQ_SIZ   = siz;
        bus.REQ_ADDR  = addr;
        bus.REQ_WDATA = wdata;
        k_req = cyc;
        if (push) begin
            e.due = k_req + lat; e.err = err; e.rdata = rdata;
            e.chk_psz = chk_psz; e.psz = psz;
            sbq.push_back(e);
        end
        bus.REQ = 1'b1;
        step();
        bus.REQ = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sbq.size() != 0 && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending completions want 0", sbq.size());
            sbq.delete();
        end
        step(2);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_nBR"},      32'(bus.nBR),      32'd1);
        chk({tag, "_nBGACK"},   32'(bus.nBGACK),   32'd1);
        chk({tag, "_nAS"},      32'(bus.nAS),      32'd1);
        chk({tag, "_nDS"},      32'(bus.nDS),      32'd1);
        chk({tag, "_RnW"},      32'(bus.RnW),      32'd1);
        chk({tag, "_SIZ"},      32'(bus.SIZ),      32'd0);
        chk({tag, "_ADDR"},     bus.ADDR,          32'd0);
        chk({tag, "_BUS_OE"},   32'(bus.BUS_OE),   32'd0);
        chk({tag, "_DATA_OE"},  32'(bus.DATA_OE),  32'd0);
        chk({tag, "_DATA_OUT"}, bus.DATA_OUT,      32'd0);
        chk({tag, "_BUSY"},     32'(bus.BUSY),     32'd0);
        chk({tag, "_DONE"},     32'(bus.DONE),     32'd0);
        chk({tag, "_ERR"},      32'(bus.ERR),      32'd0);
        chk({tag, "_RDATA"},    bus.RDATA,         32'd0);
        chk({tag, "_PORTSZ"},   32'(bus.PORTSZ),   32'd0);
    endtask

    initial begin
        #(40 * 3000);
        $display("FAIL watchdog: got no finish want finish within 3000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.REQ = 1'b0; bus.REQ_RnW = 1'b1; bus.REQ_SIZ = 2'b00;
        bus.REQ_ADDR = '0; bus.REQ_WDATA = '0; bus.DATA_IN = '0;
        bus.nBG = 1'b0; bus.nAS_IN = 1'b1; bus.nBGACK_IN = 1'b1;
        bus.nDSACK = 2'b11; bus.nSTERM = 1'b1; bus.nBERR = 1'b1;
        step(3);
        check_reset("rst");
        rst = 1'b0;
        step();

        // 1: long read, zero-wait DSACK=00
        set_rsp(1, 2'b00, 1'b0, 1'b0, 32'hDEADBEEF);
        m_rdata = 32'hDEADBEEF;
        issue(1'b1, 2'b00, 32'h0001_0000, 32'h0, 1'b1, 6, 1'b0, m_rdata, 1'b1, 2'b00);
        chk("rd_arb_nBR",  32'(bus.nBR),  32'd0);
        chk("rd_arb_busy", 32'(bus.BUSY), 32'd1);
        step(3);
        chk("rd_wait_nAS",  32'(bus.nAS),    32'd0);
        chk("rd_wait_nDS",  32'(bus.nDS),    32'd0);
        chk("rd_wait_RnW",  32'(bus.RnW),    32'd1);
        chk("rd_wait_addr", bus.ADDR,        32'h0001_0000);
        chk("rd_wait_doe",  32'(bus.DATA_OE), 32'd0);
        drain(20);

        // 2: byte write, DSACK=10 on third WAIT edge; stray REQ while busy
        set_rsp(3, 2'b10, 1'b0, 1'b0, 32'h0);
        issue(1'b0, 2'b01, 32'hFFE00003, 32'hA5A51234, 1'b1, 8, 1'b0, m_rdata, 1'b1, 2'b10);
        step(2);
        chk("wr_s1_nAS",   32'(bus.nAS),     32'd0);
        chk("wr_s1_nDS",   32'(bus.nDS),     32'd1);
        chk("wr_s1_doe",   32'(bus.DATA_OE), 32'd1);
        chk("wr_s1_dout",  bus.DATA_OUT,     32'hA5A51234);
        chk("wr_s1_RnW",   32'(bus.RnW),     32'd0);
        chk("wr_s1_siz",   32'(bus.SIZ),     32'd1);
        chk("wr_s1_addr",  bus.ADDR,         32'hFFE00003);
        bus.REQ = 1'b1; bus.REQ_ADDR = 32'h1111_1111;
        step();
        bus.REQ = 1'b0;
        chk("wr_wait_nDS", 32'(bus.nDS),     32'd0);
        chk("wr_wait_doe", 32'(bus.DATA_OE), 32'd1);
        step(3);
        chk("wr_end_nAS",   32'(bus.nAS),     32'd1);
        chk("wr_end_doe",   32'(bus.DATA_OE), 32'd0);
        chk("wr_end_busoe", 32'(bus.BUS_OE),  32'd1);
        chk("wr_end_bgack", 32'(bus.nBGACK),  32'd0);
        drain(20);

        // 3: arbitration; BG absent 5 clocks, then BG with AS busy 2 clocks
        bus.nBG = 1'b1;
        set_rsp(1, 2'b00, 1'b0, 1'b0, 32'h0BADF00D);
        m_rdata = 32'h0BADF00D;
        issue(1'b1, 2'b10, 32'h0000_2000, 32'h0, 1'b1, 13, 1'b0, m_rdata, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("arb_nobg_nBR",   32'(bus.nBR),    32'd0);
            chk("arb_nobg_bgack", 32'(bus.nBGACK), 32'd1);
        end
        bus.nBG = 1'b0; bus.nAS_IN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("arb_asbusy_nBR",   32'(bus.nBR),    32'd0);
            chk("arb_asbusy_bgack", 32'(bus.nBGACK), 32'd1);
        end
        bus.nAS_IN = 1'b1;
        step();
        chk("arb_s0_bgack", 32'(bus.nBGACK), 32'd0);
        chk("arb_s0_nBR",   32'(bus.nBR),    32'd1);
        chk("arb_s0_busoe", 32'(bus.BUS_OE), 32'd1);
        bus.nBG = 1'b1;
        drain(20);
        bus.nBG = 1'b0;

        // 4: BERR together with STERM on a read
        set_rsp(1, 2'b11, 1'b1, 1'b1, 32'h12345678);
        issue(1'b1, 2'b00, 32'h0000_3000, 32'h0, 1'b1, 6, 1'b1, m_rdata, 1'b0, 2'b00);
        drain(20);

        // 5: no termination -> 8 WAIT clocks then timeout error
        set_rsp(0, 2'b11, 1'b0, 1'b0, 32'h5555AAAA);
        issue(1'b1, 2'b00, 32'h0000_4000, 32'h0, 1'b1, 13, 1'b1, m_rdata, 1'b1, 2'b00);
        step(10);
        chk("to_last_wait_nAS", 32'(bus.nAS), 32'd0);
        step();
        chk("to_end_nAS",   32'(bus.nAS),    32'd1);
        chk("to_end_busoe", 32'(bus.BUS_OE), 32'd1);
        drain(20);

        // 6: reset pulsed in WAIT, then a normal STERM read
        set_rsp(0, 2'b11, 1'b0, 1'b0, 32'h0);
        issue(1'b1, 2'b00, 32'h0000_5000, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1'b0, 2'b00);
        step(3);
        chk("rst_pre_nAS", 32'(bus.nAS), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset("midrst");
        m_rdata = 32'h0;
        step(10);
        set_rsp(1, 2'b11, 1'b1, 1'b0, 32'hCAFEF00D);
        m_rdata = 32'hCAFEF00D;
        issue(1'b1, 2'b00, 32'h0000_6000, 32'h0, 1'b1, 6, 1'b0, m_rdata, 1'b1, 2'b11);
        drain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
